// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
// Bundles the request side (encode requests, flush) and the instruction-memory
// write side of instr_encoder into one interface.
//
// Signals:
//   req_valid/req_ready       request handshake
//   req_kind, rd, rn, rm, imm request fields
//   clear                     synchronous flush
//   wr_valid/wr_ack           memory write handshake
//   wr_addr, wr_data          memory write address / encoded word
//   busy, err, wr_count       status
//
// Modports:
//   slave  - the encoder's view
//   master - the requester / memory-model view
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
   parameter int ADDR_W = 6
) ();

   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_kind;
   logic [4:0]        rd;
   logic [4:0]        rn;
   logic [4:0]        rm;
   logic [18:0]       imm;
   logic              clear;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              wr_ack;
   logic              busy;
   logic              err;
   logic [ADDR_W:0]   wr_count;

   modport slave (
      input  req_valid, req_kind, rd, rn, rm, imm, clear, wr_ack,
      output req_ready, wr_valid, wr_addr, wr_data, busy, err, wr_count
   );

   modport master (
      output req_valid, req_kind, rd, rn, rm, imm, clear, wr_ack,
      input  req_ready, wr_valid, wr_addr, wr_data, busy, err, wr_count
   );

endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Encodes ARM LEGv8-subset instructions (LDUR, STUR, CBZ, CBNZ, ADD, SUB, AND,
// ORR, ADDI) into 32-bit machine words. It buffers the words in a small FIFO
// and writes them to consecutive instruction-memory addresses.
//
// Ports:
//   clk    - single clock, rising edge
//   reset  - asynchronous, active-low reset
//   bus    - instr_encoder_if.slave. It carries:
//              * the request handshake and fields
//              * the synchronous flush (clear)
//              * the memory write handshake (wr_valid/wr_ack, wr_addr, wr_data)
//              * status (busy, sticky err, saturating wr_count)
//
// Parameters:
//   FIFO_DEPTH - buffered words (power of two, >= 2)
//   ADDR_W     - instruction-memory word-address width
// ---------------------------------------------------------------------------
module instr_encoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 6
) (
   input  logic           clk,
   input  logic           reset,
   instr_encoder_if.slave bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   WCNT_ZERO = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0]   WCNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   WCNT_MAX  = {(ADDR_W+1){1'b1}};

   localparam logic [3:0] K_LDUR = 4'd0;
   localparam logic [3:0] K_STUR = 4'd1;
   localparam logic [3:0] K_CBZ  = 4'd2;
   localparam logic [3:0] K_CBNZ = 4'd3;
   localparam logic [3:0] K_ADD  = 4'd4;
   localparam logic [3:0] K_SUB  = 4'd5;
   localparam logic [3:0] K_AND  = 4'd6;
   localparam logic [3:0] K_ORR  = 4'd7;
   localparam logic [3:0] K_ADDI = 4'd8;

   // Returns {valid, word}. An invalid kind yields valid=0 and a zero word.
   // The CB-type Rt field sits in the rd input; unused imm bits drop out.
   function automatic logic [32:0] encode_word(
      input logic [3:0]  kind,
      input logic [4:0]  f_rd,
      input logic [4:0]  f_rn,
      input logic [4:0]  f_rm,
      input logic [18:0] f_imm
   );
      logic [32:0] res;
      res = 33'h0;
      case (kind)
         K_LDUR:  res = {1'b1, 11'b11111000010, f_imm[8:0], 2'b00, f_rn, f_rd};
         K_STUR:  res = {1'b1, 11'b11111000000, f_imm[8:0], 2'b00, f_rn, f_rd};
         K_CBZ:   res = {1'b1, 8'b10110100, f_imm[18:0], f_rd};
         K_CBNZ:  res = {1'b1, 8'b10110101, f_imm[18:0], f_rd};
         K_ADD:   res = {1'b1, 11'b10001011000, f_rm, 6'b000000, f_rn, f_rd};
         K_SUB:   res = {1'b1, 11'b11001011000, f_rm, 6'b000000, f_rn, f_rd};
         K_AND:   res = {1'b1, 11'b10001010000, f_rm, 6'b000000, f_rn, f_rd};
         K_ORR:   res = {1'b1, 11'b10101010000, f_rm, 6'b000000, f_rn, f_rd};
         K_ADDI:  res = {1'b1, 10'b1001000100, f_imm[11:0], f_rn, f_rd};
         default: res = 33'h0;
      endcase
      return res;
   endfunction

   logic [31:0]       mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  count_nxt_s;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W:0]   wcnt_r;
   logic              err_r;
   logic              alive_r;

   logic [32:0]       enc_s;
   logic              enc_ok_s;
   logic [31:0]       enc_word_s;
   logic              full_s;
   logic              busy_s;
   logic              ready_s;
   logic              accept_s;
   logic              push_s;
   logic              bad_s;
   logic              pop_s;

   // Combinational encoding of the request currently presented.
   always_comb begin
      enc_s      = encode_word(bus.req_kind, bus.rd, bus.rn, bus.rm, bus.imm);
      enc_ok_s   = enc_s[32];
      enc_word_s = enc_s[31:0];
   end

   // Handshake qualifiers. alive_r keeps req_ready low until the first edge
   // after reset release. Clear blocks both accept and pop. Acceptance while
   // full is refused even if the head is being popped in the same cycle.
   always_comb begin
      full_s   = (count_r == DEPTH_C);
      busy_s   = (count_r != CNT_ZERO);
      ready_s  = alive_r && !full_s && !bus.clear;
      accept_s = bus.req_valid && ready_s;
      push_s   = accept_s && enc_ok_s;
      bad_s    = accept_s && !enc_ok_s;
      pop_s    = busy_s && bus.wr_ack && !bus.clear;
   end

   // Next FIFO occupancy: a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // FIFO storage; entries are zeroed on reset so nothing stale survives it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 32'h0;
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= enc_word_s;
      end
   end

   // Pointers, occupancy, write address, write count and sticky error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
         addr_r   <= ADDR_ZERO;
         wcnt_r   <= WCNT_ZERO;
         err_r    <= 1'b0;
         alive_r  <= 1'b0;
      end else if (bus.clear) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
         addr_r   <= ADDR_ZERO;
         wcnt_r   <= WCNT_ZERO;
         err_r    <= 1'b0;
         alive_r  <= 1'b1;
      end else begin
         alive_r <= 1'b1;
         count_r <= count_nxt_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
            // The address wraps naturally at 2^ADDR_W.
            addr_r   <= addr_r + ADDR_ONE;
            if (wcnt_r != WCNT_MAX) begin
               wcnt_r <= wcnt_r + WCNT_ONE;
            end
         end
         if (bad_s) begin
            err_r <= 1'b1;
         end
      end
   end

   assign bus.req_ready = ready_s;
   assign bus.wr_valid  = busy_s;
   assign bus.busy      = busy_s;
   // The head is forced to zero when empty so an idle bus never shows a stale word.
   assign bus.wr_data   = busy_s ? mem_r[rd_ptr_r] : 32'h0;
   assign bus.wr_addr   = addr_r;
   assign bus.wr_count  = wcnt_r;
   assign bus.err       = err_r;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench for instr_encoder.
//
// A queue-based reference model tracks the expected state on every edge. A
// compare process checks all DUT outputs against it on each falling edge.
// Directed scenarios pin literal expected words, addresses and counts.
// A randomized phase then exercises mixed traffic.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

   localparam int DEPTH = 4;
   localparam int AW    = 6;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   instr_encoder_if #(.ADDR_W(AW)) bus ();

   instr_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state.
   longint mq[$];
   int     m_addr  = 0;
   int     m_cnt   = 0;
   bit     m_err   = 1'b0;
   bit     m_alive = 1'b0;

   // Log of writes observed on the memory side.
   int     log_addr[$];
   longint log_data[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Builds the machine word from field values by weighted sums; returns -1 for an invalid kind.
   function automatic longint model_enc(input int kind, input int f_rd, input int f_rn,
                                        input int f_rm, input longint f_imm);
      longint r_base;
      longint d_base;
      r_base = longint'(f_rm) * 65536 + longint'(f_rn) * 32 + f_rd;
      d_base = (f_imm % 512) * 4096 + longint'(f_rn) * 32 + f_rd;
      case (kind)
         0:       return longint'('h7C2) * 2097152 + d_base;
         1:       return longint'('h7C0) * 2097152 + d_base;
         2:       return longint'('hB4) * 16777216 + (f_imm % 524288) * 32 + f_rd;
         3:       return longint'('hB5) * 16777216 + (f_imm % 524288) * 32 + f_rd;
         4:       return longint'('h458) * 2097152 + r_base;
         5:       return longint'('h658) * 2097152 + r_base;
         6:       return longint'('h450) * 2097152 + r_base;
         7:       return longint'('h550) * 2097152 + r_base;
         8:       return longint'('h244) * 4194304 + (f_imm % 4096) * 1024 + longint'(f_rn) * 32 + f_rd;
         default: return -1;
      endcase
   endfunction

   // Reference model: advances on every rising edge and resets asynchronously.
   initial begin
      bit     rdy;
      bit     acc;
      bit     pop;
      longint w;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            mq.delete();
            m_addr  = 0;
            m_cnt   = 0;
            m_err   = 1'b0;
            m_alive = 1'b0;
         end else begin
            if (bus.clear) begin
               mq.delete();
               m_addr = 0;
               m_cnt  = 0;
               m_err  = 1'b0;
            end else begin
               rdy = m_alive && (mq.size() < DEPTH);
               acc = bus.req_valid && rdy;
               pop = (mq.size() > 0) && bus.wr_ack;
               if (pop) begin
                  void'(mq.pop_front());
                  m_addr = (m_addr + 1) % (1 << AW);
                  if (m_cnt < (1 << (AW + 1)) - 1) m_cnt++;
               end
               if (acc) begin
                  w = model_enc(int'(bus.req_kind), int'(bus.rd), int'(bus.rn),
                                int'(bus.rm), longint'(bus.imm));
                  if (w < 0) m_err = 1'b1;
                  else       mq.push_back(w);
               end
            end
            m_alive = 1'b1;
         end
      end
   end

   // Compare process: all outputs against the model on every falling edge, plus a write log.
   initial begin
      forever begin
         @(negedge clk);
         check("req_ready", bus.req_ready,
               (reset && m_alive && (mq.size() < DEPTH) && !bus.clear) ? 1 : 0);
         check("wr_valid", bus.wr_valid, (mq.size() > 0) ? 1 : 0);
         check("busy", bus.busy, (mq.size() > 0) ? 1 : 0);
         check("wr_data", bus.wr_data, (mq.size() > 0) ? mq[0] : 0);
         check("wr_addr", bus.wr_addr, m_addr);
         check("wr_count", bus.wr_count, m_cnt);
         check("err", bus.err, m_err);
         if (reset && !bus.clear && bus.wr_valid && bus.wr_ack) begin
            log_addr.push_back(int'(bus.wr_addr));
            log_data.push_back(longint'(bus.wr_data));
         end
      end
   end

   // Global time limit.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_pulse();
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
   endtask

   task automatic set_req(input int kind, input int f_rd, input int f_rn, input int f_rm, input int f_imm);
      bus.req_kind  = 4'(kind);
      bus.rd        = 5'(f_rd);
      bus.rn        = 5'(f_rn);
      bus.rm        = 5'(f_rm);
      bus.imm       = 19'(f_imm);
      bus.req_valid = 1'b1;
   endtask

   // Waits (bounded) for the accept edge of the request currently presented.
   task automatic wait_accept();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            got = 1'b1;
            break;
         end
      end
      check("accept_in_time", got, 1);
      step();
      bus.req_valid = 1'b0;
   endtask

   task automatic send(input int kind, input int f_rd, input int f_rn, input int f_rm, input int f_imm);
      set_req(kind, f_rd, f_rn, f_rm, f_imm);
      wait_accept();
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_kind  = 4'd0;
      bus.rd        = 5'd0;
      bus.rn        = 5'd0;
      bus.rm        = 5'd0;
      bus.imm       = 19'd0;
      bus.clear     = 1'b0;
      bus.wr_ack    = 1'b0;

      // Pin the model against hand-computed words.
      check("model_add",  model_enc(4, 3, 1, 2, 0), 64'h8B020023);
      check("model_ldur", model_enc(0, 5, 2, 0, 8), 64'hF8408045);
      check("model_addi", model_enc(8, 1, 0, 0, 5), 64'h91001401);
      check("model_cbz",  model_enc(2, 7, 0, 0, 3), 64'hB4000067);
      check("model_bad",  (model_enc(12, 0, 0, 0, 0) < 0) ? 1 : 0, 1);

      // Reset state.
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_wr_valid", bus.wr_valid, 0);
      check("rst_wr_data", bus.wr_data, 0);
      check("rst_wr_count", bus.wr_count, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      step();
      @(negedge clk);
      check("ready_after_release", bus.req_ready, 1);

      // Single ADD with wr_ack held high.
      step();
      bus.wr_ack = 1'b1;
      send(4, 3, 1, 2, 0);
      @(negedge clk);
      check("add_wr_valid", bus.wr_valid, 1);
      check("add_wr_data", bus.wr_data, 32'h8B020023);
      check("add_wr_addr", bus.wr_addr, 0);
      step();
      step();
      @(negedge clk);
      check("add_wr_count", bus.wr_count, 1);

      // Back-to-back LDUR, ADDI, CBZ.
      step();
      clear_pulse();
      log_addr.delete();
      log_data.delete();
      send(0, 5, 2, 0, 8);
      send(8, 1, 0, 0, 5);
      send(2, 7, 0, 0, 3);
      repeat (5) step();
      check("b2b_count", log_data.size(), 3);
      if (log_data.size() == 3) begin
         check("b2b_w0", log_data[0], 64'hF8408045);
         check("b2b_w1", log_data[1], 64'h91001401);
         check("b2b_w2", log_data[2], 64'hB4000067);
         check("b2b_a0", log_addr[0], 0);
         check("b2b_a1", log_addr[1], 1);
         check("b2b_a2", log_addr[2], 2);
      end

      // Fill the FIFO with wr_ack low, hold a fifth request, then drain.
      clear_pulse();
      log_addr.delete();
      log_data.delete();
      bus.wr_ack = 1'b0;
      for (int i = 1; i <= 4; i++) send(4, i, 0, 0, 0);
      set_req(4, 5, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("full_ready_low", bus.req_ready, 0);
         check("full_head_stable", bus.wr_data, 32'h8B000001);
      end
      step();
      bus.wr_ack = 1'b1;
      wait_accept();
      repeat (10) step();
      check("full_drain_count", log_data.size(), 5);
      if (log_data.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            check("full_drain_addr", log_addr[i], i);
            check("full_drain_data", log_data[i], 64'h8B000001 + i);
         end
      end

      // Invalid kind sets sticky err without pushing.
      clear_pulse();
      log_addr.delete();
      log_data.delete();
      send(12, 1, 1, 1, 1);
      @(negedge clk);
      check("bad_err", bus.err, 1);
      check("bad_busy", bus.busy, 0);
      repeat (3) step();
      @(negedge clk);
      check("bad_err_sticky", bus.err, 1);
      check("bad_no_write", log_data.size(), 0);
      step();
      clear_pulse();
      @(negedge clk);
      check("bad_err_cleared", bus.err, 0);

      // Address wrap after 63 writes, then counter saturation.
      step();
      clear_pulse();
      for (int i = 0; i < 63; i++) send(7, i % 32, 1, 2, 0);
      repeat (4) step();
      @(negedge clk);
      check("wrap_pre_addr", bus.wr_addr, 63);
      check("wrap_pre_count", bus.wr_count, 63);
      step();
      send(5, 1, 2, 3, 0);
      repeat (4) step();
      @(negedge clk);
      check("wrap_addr", bus.wr_addr, 0);
      check("wrap_count", bus.wr_count, 64);
      step();
      for (int i = 0; i < 70; i++) send(6, i % 32, 3, 4, 0);
      repeat (4) step();
      @(negedge clk);
      check("sat_count", bus.wr_count, 127);
      check("sat_addr", bus.wr_addr, 6);

      // Reset mid-transfer with three words buffered.
      step();
      bus.wr_ack = 1'b0;
      send(4, 1, 1, 1, 0);
      send(4, 2, 2, 2, 0);
      send(4, 3, 3, 3, 0);
      @(negedge clk);
      check("pre_rst_valid", bus.wr_valid, 1);
      #2 reset = 1'b0;
      #1;
      check("async_rst_valid", bus.wr_valid, 0);
      check("async_rst_busy", bus.busy, 0);
      check("async_rst_count", bus.wr_count, 0);
      repeat (2) @(posedge clk);
      log_addr.delete();
      log_data.delete();
      #1 reset = 1'b1;
      bus.wr_ack = 1'b1;
      repeat (5) step();
      check("no_write_after_rst", log_data.size(), 0);

      // Randomized traffic; the compare process checks every cycle.
      for (int seg = 0; seg < 6; seg++) begin
         int ack_pct;
         ack_pct = (seg % 3 == 0) ? 20 : ((seg % 3 == 1) ? 60 : 95);
         for (int c = 0; c < 500; c++) begin
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_kind  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15))
                                                        : 4'($urandom_range(0, 8));
            bus.rd        = 5'($urandom);
            bus.rn        = 5'($urandom);
            bus.rm        = 5'($urandom);
            bus.imm       = 19'($urandom);
            bus.wr_ack    = ($urandom_range(0, 99) < ack_pct);
            bus.clear     = ($urandom_range(0, 149) == 0);
            step();
         end
      end
      bus.req_valid = 1'b0;
      bus.clear     = 1'b0;
      bus.wr_ack    = 1'b1;
      repeat (8) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
